// File: rtl/key_expander.sv
// AES-128 key expander: writes round keys 0..NUM_ROUNDS, one every 5 cycles, through one shared S-box.
// Latency: round 0 one cycle after start, done 5*NUM_ROUNDS+2 cycles after start; start is ignored while busy.
module key_expander #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipher_key,
    output logic         key_reg_load,
    output logic [3:0]   iter_in,
    output logic [127:0] key_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUB, S_GEN, S_DONE} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t        r_state;
    state_t        w_next_state;
    logic [127:0]  r_w;
    logic [3:0]    r_round;
    logic [1:0]    r_byte_idx;
    logic [7:0]    r_rcon;
    logic [31:0]   r_t;

    logic [31:0]   w_rot;
    logic [7:0]    w_sbox_in;
    logic [7:0]    w_sbox_out;
    logic [31:0]   w_n0, w_n1, w_n2, w_n3;
    logic [127:0]  w_next_key;
    logic [7:0]    w_xtime;
    logic          w_last_round;

    assign w_rot        = {r_w[23:0], r_w[31:24]};
    assign w_sbox_out   = SBOX[w_sbox_in];
    assign w_n0         = r_w[127:96] ^ r_t ^ {r_rcon, 24'h0};
    assign w_n1         = r_w[95:64] ^ w_n0;
    assign w_n2         = r_w[63:32] ^ w_n1;
    assign w_n3         = r_w[31:0] ^ w_n2;
    assign w_next_key   = {w_n0, w_n1, w_n2, w_n3};
    assign w_xtime      = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    assign w_last_round = (r_round == LAST_ROUND);

    // Byte 0 of the rotated word is its most significant byte.
    always_comb begin
        w_sbox_in = 8'h00;
        case (r_byte_idx)
            2'd0: w_sbox_in = w_rot[31:24];
            2'd1: w_sbox_in = w_rot[23:16];
            2'd2: w_sbox_in = w_rot[15:8];
            2'd3: w_sbox_in = w_rot[7:0];
            default: w_sbox_in = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        key_reg_load = 1'b0;
        iter_in      = 4'd0;
        key_out      = 128'h0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                key_reg_load = 1'b1;
                key_out      = r_w;
                busy         = 1'b1;
                w_next_state = S_SUB;
            end
            S_SUB: begin
                busy = 1'b1;
                if (r_byte_idx == 2'd3) w_next_state = S_GEN;
            end
            S_GEN: begin
                key_reg_load = 1'b1;
                iter_in      = r_round;
                key_out      = w_next_key;
                busy         = 1'b1;
                w_next_state = w_last_round ? S_DONE : S_SUB;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w        <= 128'h0;
            r_round    <= 4'd0;
            r_byte_idx <= 2'd0;
            r_rcon     <= 8'h01;
            r_t        <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w     <= cipher_key;
                        r_round <= 4'd0;
                        r_rcon  <= 8'h01;
                    end
                end
                S_LOAD: begin
                    r_round    <= 4'd1;
                    r_byte_idx <= 2'd0;
                end
                S_SUB: begin
                    case (r_byte_idx)
                        2'd0: r_t[31:24] <= w_sbox_out;
                        2'd1: r_t[23:16] <= w_sbox_out;
                        2'd2: r_t[15:8]  <= w_sbox_out;
                        2'd3: r_t[7:0]   <= w_sbox_out;
                        default: r_t <= r_t;
                    endcase
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
                S_GEN: begin
                    r_w <= w_next_key;
                    if (!w_last_round) begin
                        r_round    <= r_round + 4'd1;
                        r_rcon     <= w_xtime;
                        r_byte_idx <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expander.sv
// Directed bench for key_expander: FIPS-197 vectors, start/reset corner cases, and a NUM_ROUNDS=1 instance.
module tb_key_expander;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start1;
    logic [127:0] cipher_key;
    logic         key_reg_load, busy, done;
    logic [3:0]   iter_in;
    logic [127:0] key_out;
    logic         key_reg_load1, busy1, done1;
    logic [3:0]   iter_in1;
    logic [127:0] key_out1;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    always #5 clk = ~clk;

    key_expander #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .cipher_key(cipher_key),
        .key_reg_load(key_reg_load), .iter_in(iter_in), .key_out(key_out),
        .busy(busy), .done(done)
    );

    key_expander #(.NUM_ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cipher_key(cipher_key),
        .key_reg_load(key_reg_load1), .iter_in(iter_in1), .key_out(key_out1),
        .busy(busy1), .done(done1)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0; cipher_key = FIPS_KEY;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({key_reg_load, iter_in, key_out, busy, done} !== 135'h0) begin
            fails++;
            $display("FAIL reset_outputs: load=%0b iter=%0d key=%h busy=%0b done=%0b, required all 0",
                     key_reg_load, iter_in, key_out, busy, done);
        end
        tests++;
        if ({key_reg_load1, iter_in1, key_out1, busy1, done1} !== 135'h0) begin
            fails++;
            $display("FAIL reset_outputs_nr1: load=%0b iter=%0d busy=%0b done=%0b, required all 0",
                     key_reg_load1, iter_in1, busy1, done1);
        end
        tests++;
        if (dut.r_rcon !== 8'h01) begin
            fails++;
            $display("FAIL reset_rcon: got %h, required 01", dut.r_rcon);
        end
    endtask

    // Full FIPS-197 expansion, checked every cycle; the key input is scrambled after acceptance.
    task automatic test_fips_vector(input string tag);
        int n_loads = 0;
        cipher_key = FIPS_KEY;
        start = 1'b1;
        for (int cyc = 1; cyc <= 53; cyc++) begin
            int r;
            logic         e_load, e_busy, e_done;
            logic [3:0]   e_iter;
            logic [127:0] e_key;
            @(negedge clk);
            r      = (cyc - 1) / 5;
            e_load = (cyc <= 51) && ((cyc - 1) % 5 == 0);
            e_iter = e_load ? 4'(r) : 4'd0;
            e_key  = e_load ? fips_rk[r] : 128'h0;
            e_busy = (cyc <= 51);
            e_done = (cyc == 52);
            if (key_reg_load) n_loads++;
            tests++;
            if (key_reg_load !== e_load || iter_in !== e_iter || key_out !== e_key) begin
                fails++;
                $display("FAIL %s_write c%0d: load=%0b iter=%0d key=%h, required load=%0b iter=%0d key=%h",
                         tag, cyc, key_reg_load, iter_in, key_out, e_load, e_iter, e_key);
            end
            tests++;
            if (busy !== e_busy || done !== e_done) begin
                fails++;
                $display("FAIL %s_status c%0d: busy=%0b done=%0b, required busy=%0b done=%0b",
                         tag, cyc, busy, done, e_busy, e_done);
            end
            if (e_load && r >= 1) begin
                tests++;
                if (dut.r_rcon !== rcon_tab[r-1]) begin
                    fails++;
                    $display("FAIL %s_rcon round %0d: got %h, required %h", tag, r, dut.r_rcon, rcon_tab[r-1]);
                end
            end
            if (cyc == 1) begin
                start = 1'b0;
                cipher_key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
            end
        end
        tests++;
        if (n_loads != 11) begin
            fails++;
            $display("FAIL %s_load_count: got %0d, required 11", tag, n_loads);
        end
    endtask

    task automatic test_second_key();
        cipher_key = KEY2;
        start = 1'b1;
        for (int cyc = 1; cyc <= 53; cyc++) begin
            logic e_load;
            @(negedge clk);
            e_load = (cyc <= 51) && ((cyc - 1) % 5 == 0);
            tests++;
            if (key_reg_load !== e_load || iter_in !== (e_load ? 4'((cyc - 1) / 5) : 4'd0) || done !== (cyc == 52)) begin
                fails++;
                $display("FAIL key2_timing c%0d: load=%0b iter=%0d done=%0b, required load=%0b iter=%0d done=%0b",
                         cyc, key_reg_load, iter_in, done, e_load, (e_load ? (cyc - 1) / 5 : 0), (cyc == 52));
            end
            if (cyc == 1 || cyc == 51) begin
                tests++;
                if (key_out !== ((cyc == 1) ? KEY2 : KEY2_R10)) begin
                    fails++;
                    $display("FAIL key2_round c%0d: got %h, required %h", cyc, key_out, ((cyc == 1) ? KEY2 : KEY2_R10));
                end
            end
            if (cyc == 1) start = 1'b0;
        end
    endtask

    // start held high: the second expansion is accepted only once back in IDLE, with the key present then.
    task automatic test_start_held();
        cipher_key = FIPS_KEY;
        start = 1'b1;
        for (int cyc = 1; cyc <= 58; cyc++) begin
            logic         e_load, e_busy, e_done;
            logic [3:0]   e_iter;
            logic [127:0] e_key;
            @(negedge clk);
            if (cyc <= 53) begin
                e_load = (cyc <= 51) && ((cyc - 1) % 5 == 0);
                e_iter = e_load ? 4'((cyc - 1) / 5) : 4'd0;
                e_key  = e_load ? fips_rk[(cyc - 1) / 5] : 128'h0;
                e_busy = (cyc <= 51);
                e_done = (cyc == 52);
            end else begin
                e_load = (cyc == 54);
                e_iter = 4'd0;
                e_key  = e_load ? KEY2 : 128'h0;
                e_busy = 1'b1;
                e_done = 1'b0;
            end
            tests++;
            if (key_reg_load !== e_load || iter_in !== e_iter || key_out !== e_key || busy !== e_busy || done !== e_done) begin
                fails++;
                $display("FAIL held_start c%0d: load=%0b iter=%0d key=%h busy=%0b done=%0b, required %0b %0d %h %0b %0b",
                         cyc, key_reg_load, iter_in, key_out, busy, done, e_load, e_iter, e_key, e_busy, e_done);
            end
            if (cyc == 10) cipher_key = KEY2;
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        cipher_key = FIPS_KEY;
        start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            logic         e_load, e_busy;
            logic [3:0]   e_iter;
            logic [127:0] e_key;
            @(negedge clk);
            e_load = (cyc <= 20) && ((cyc - 1) % 5 == 0);
            e_iter = e_load ? 4'((cyc - 1) / 5) : 4'd0;
            e_key  = e_load ? fips_rk[(cyc - 1) / 5] : 128'h0;
            e_busy = (cyc <= 20);
            tests++;
            if (key_reg_load !== e_load || iter_in !== e_iter || key_out !== e_key || busy !== e_busy || done !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid c%0d: load=%0b iter=%0d key=%h busy=%0b done=%0b, required %0b %0d %h %0b 0",
                         cyc, key_reg_load, iter_in, key_out, busy, done, e_load, e_iter, e_key, e_busy);
            end
            if (cyc == 1)  start = 1'b0;
            if (cyc == 20) rst = 1'b1;
            if (cyc == 21) rst = 1'b0;
        end
    endtask

    task automatic test_num_rounds1();
        cipher_key = FIPS_KEY;
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            logic         e_load;
            logic [3:0]   e_iter;
            logic [127:0] e_key;
            @(negedge clk);
            e_load = (cyc == 1) || (cyc == 6);
            e_iter = (cyc == 6) ? 4'd1 : 4'd0;
            e_key  = (cyc == 1) ? fips_rk[0] : ((cyc == 6) ? fips_rk[1] : 128'h0);
            tests++;
            if (key_reg_load1 !== e_load || iter_in1 !== e_iter || key_out1 !== e_key ||
                busy1 !== (cyc <= 6) || done1 !== (cyc == 7)) begin
                fails++;
                $display("FAIL nr1 c%0d: load=%0b iter=%0d key=%h busy=%0b done=%0b, required %0b %0d %h %0b %0b",
                         cyc, key_reg_load1, iter_in1, key_out1, busy1, done1, e_load, e_iter, e_key, (cyc <= 6), (cyc == 7));
            end
            if (cyc == 1) start1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_fips_vector("fips");
        test_second_key();
        test_start_held();
        test_reset_mid();
        test_fips_vector("restart");
        test_num_rounds1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
